// File: rtl/par4_pkg.sv
// Shared definitions for the 4-bit parity link: receiver state encoding,
// frame geometry and the parity helper shared with the transmit side.
package par4_pkg;

   localparam int PAR4_DATA_W = 4;
   localparam int FRAME_BITS  = PAR4_DATA_W + 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      WAIT   = 3'd4
   } rx_state_t;

   function automatic logic par_calc(input logic [PAR4_DATA_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/par4_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module par4_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/par4_serial_rx.sv
// Serial receiver for the 4-bit parity link: start, payload MSB first,
// even parity, stop. Optional error counter under PAR4_RX_ERRCNT_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a start bit (any 0)
// DATA   | shifting payload bits, accumulating parity
// PARITY | sampling parity bit, latching mismatch
// STOP   | sampling stop bit, issuing status pulse
// WAIT   | framing error seen, waiting for line to return high
module par4_serial_rx
   import par4_pkg::*;
#(
   parameter int DATA_W = PAR4_DATA_W
`ifdef PAR4_RX_ERRCNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in,
   output logic [DATA_W-1:0] data_out,
   output logic              done,
   output logic              par_err,
   output logic              frm_err
`ifdef PAR4_RX_ERRCNT_EN
   , output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam int            CW   = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   rx_state_t         state, state_nxt;
   logic [DATA_W-1:0] shift_q;
   logic [CW-1:0]     bit_cnt;
   logic              run_par;
   logic              mismatch;
   logic              done_nxt, par_err_nxt, frm_err_nxt, load_data;

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!in) state_nxt = DATA;
         DATA:    if (bit_cnt == LAST) state_nxt = PARITY;
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = in ? IDLE : WAIT;
         WAIT:    if (in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      done_nxt    = 1'b0;
      par_err_nxt = 1'b0;
      frm_err_nxt = 1'b0;
      load_data   = 1'b0;
      if (state == STOP) begin
         if (in) begin
            load_data   = 1'b1;
            done_nxt    = !mismatch;
            par_err_nxt = mismatch;
         end else begin
            frm_err_nxt = 1'b1;
         end
      end
   end

   // Pulses are registered so they appear the cycle after the stop bit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         shift_q  <= '0;
         bit_cnt  <= '0;
         run_par  <= 1'b0;
         mismatch <= 1'b0;
         data_out <= '0;
         done     <= 1'b0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         done    <= done_nxt;
         par_err <= par_err_nxt;
         frm_err <= frm_err_nxt;
         if (load_data)
            data_out <= shift_q;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               run_par <= 1'b0;
            end
            DATA: begin
               shift_q <= {shift_q[DATA_W-2:0], in};
               run_par <= run_par ^ in;
               bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: mismatch <= run_par ^ in;
            default: ;
         endcase
      end
   end

`ifdef PAR4_RX_ERRCNT_EN
   // Counts on the same edge that registers the error pulse.
   par4_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (1'b0),
      .inc    (par_err_nxt | frm_err_nxt),
      .cnt    (err_cnt)
   );
`endif

endmodule

// File: tb/tb_par4_serial_rx.sv
// Bench for par4_serial_rx: table of frames plus hand-written corner
// sequences; expected pulses go through a queue checked at each pulse.
module tb_par4_serial_rx;
   import par4_pkg::*;

   localparam int K_DONE = 0;
   localparam int K_PAR  = 1;
   localparam int K_FRM  = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       line = 1'b1;
   logic [3:0] data_out;
   logic       done, par_err, frm_err;
`ifdef PAR4_RX_ERRCNT_EN
   logic [1:0] err_cnt;
   int         err_model = 0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_seen = 0;

   typedef struct {
      int         kind;
      logic [3:0] data;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [3:0] data;
      logic       flip;
      logic       stop;
      int         exp_kind;
      logic [3:0] exp_data;
   } vec_t;
   vec_t vecs[4];

`ifdef PAR4_RX_ERRCNT_EN
   par4_serial_rx #(.DATA_W(4), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn), .in(line), .data_out(data_out),
      .done(done), .par_err(par_err), .frm_err(frm_err), .err_cnt(err_cnt));
`else
   par4_serial_rx #(.DATA_W(4)) dut (
      .clk(clk), .resetn(resetn), .in(line), .data_out(data_out),
      .done(done), .par_err(par_err), .frm_err(frm_err));
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clk);
      #1 line = b;
   endtask

   task automatic send_frame(input logic [3:0] d, input logic flip, input logic stop,
                             input int kind, input logic [3:0] exp_data);
      exp_t e;
      drive_bit(1'b0);
      for (int i = 3; i >= 0; i--) drive_bit(d[i]);
      drive_bit(par_calc(d) ^ flip);
      drive_bit(stop);
      e.kind = kind;
      e.data = exp_data;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 resetn = 1'b0;
      line = 1'b1;
      exp_q.delete();
`ifdef PAR4_RX_ERRCNT_EN
      err_model = 0;
`endif
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic chk_idle_state(input string tag);
      @(negedge clk);
      chk({tag, "_data_out"}, int'(data_out), 0);
      chk({tag, "_pulses"}, int'({done, par_err, frm_err}), 0);
`ifdef PAR4_RX_ERRCNT_EN
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
   endtask

   // Scoreboard: every pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (resetn && (done || par_err || frm_err)) begin
         automatic int kind = done ? K_DONE : (par_err ? K_PAR : K_FRM);
         automatic exp_t e;
         chk("pulse_exclusive", int'(done) + int'(par_err) + int'(frm_err), 1);
         if (done) done_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse_kind", kind, -1);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_data_out", int'(data_out), int'(e.data));
            chk("pulse_timing", cyc, e.cyc + 1);
`ifdef PAR4_RX_ERRCNT_EN
            if (e.kind != K_DONE && err_model < 3) err_model++;
            chk("err_cnt", int'(err_cnt), err_model);
`endif
         end
      end
   end

   initial begin
      int seen0;
      vecs[0] = '{4'hB, 1'b0, 1'b1, K_DONE, 4'hB};
      vecs[1] = '{4'h6, 1'b1, 1'b1, K_PAR,  4'h6};
      vecs[2] = '{4'h3, 1'b0, 1'b0, K_FRM,  4'h6};
      vecs[3] = '{4'h9, 1'b0, 1'b1, K_DONE, 4'h9};

      do_reset();
      chk_idle_state("reset");
      drive_bit(1'b1);

      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop,
                    vecs[i].exp_kind, vecs[i].exp_data);
         if (!vecs[i].stop) begin
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b1);
         end
      end
      repeat (3) drive_bit(1'b1);

      // Zero-gap stream of all payloads; timing check enforces 7-cycle spacing.
      seen0 = done_seen;
      for (int v = 0; v < 16; v++)
         send_frame(4'(v), 1'b0, 1'b1, K_DONE, 4'(v));
      repeat (3) drive_bit(1'b1);
      chk("b2b_done_count", done_seen - seen0, 16);
      chk("b2b_queue_drained", exp_q.size(), 0);

      // Reset in the middle of payload 4'hA: frame discarded silently.
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      do_reset();
      chk_idle_state("midreset");
      repeat (2) drive_bit(1'b1);
      send_frame(4'h5, 1'b0, 1'b1, K_DONE, 4'h5);
      repeat (3) drive_bit(1'b1);
      chk("midreset_queue_drained", exp_q.size(), 0);

`ifdef PAR4_RX_ERRCNT_EN
      do_reset();
      drive_bit(1'b1);
      for (int i = 0; i < 5; i++)
         send_frame(4'(i + 1), 1'b1, 1'b1, K_PAR, 4'(i + 1));
      repeat (3) drive_bit(1'b1);
      @(negedge clk);
      chk("err_cnt_saturated", int'(err_cnt), 3);
`endif

      repeat (5) drive_bit(1'b1);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
